// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. It carries NUM_WORDS data lanes of WORD_W bits plus a FLAG_W flag
// vector. in_ready is a flop, so downstream backpressure never forms a
// combinational path back into the upstream stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready).
// A producer holds valid and its data stable until the transfer. in_ready
// depends only on the stage's own state and never on out_ready.
//
// Ports
//   clock      rising-edge clock
//   clrn       asynchronous active-low reset
//   flush      synchronous flush; drops both entries and any input this cycle
//   in_valid   upstream has data
//   in_ready   registered; stage can accept data (0 only when both entries are full)
//   in_words   upstream lanes; lane k is bits [k*WORD_W +: WORD_W]
//   in_flags   upstream flags
//   out_valid  main entry is valid
//   out_ready  downstream accepts data
//   out_words  output lanes; a NOP bubble when out_valid is 0
//   out_flags  output flags; 0 when out_valid is 0
//   occupancy  number of valid entries (0..2); this is also the FSM state
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
    parameter int unsigned         WORD_W    = 32,
    parameter int unsigned         NUM_WORDS = 4,
    parameter int unsigned         FLAG_W    = 2,
    parameter int unsigned         IR_LANE   = 1,
    parameter logic [WORD_W-1:0]   NOP_WORD  = '0,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic                          clock,
    input  logic                          clrn,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]   in_words,
    input  logic [FLAG_W-1:0]             in_flags,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_WORDS*WORD_W-1:0]   out_words,
    output logic [FLAG_W-1:0]             out_flags,
    output logic [1:0]                    occupancy,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int unsigned     DW      = NUM_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Encoding equals the number of valid entries, so the state doubles as
    // the occupancy output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DW-1:0]     main_words_q, main_words_d;
    logic [FLAG_W-1:0] main_flags_q, main_flags_d;
    logic [DW-1:0]     skid_words_q, skid_words_d;
    logic [FLAG_W-1:0] skid_flags_q, skid_flags_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic in_fire, out_fire;
    logic load_main, load_skid, move_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                // in_ready is 0 here, so only the drain side can move.
                if (out_fire) begin
                    move_skid = 1'b1;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides everything: whatever arrives this cycle is dropped;
        // an out_fire in the same cycle has already been taken downstream.
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    always_comb begin
        main_valid_d = (state_d != EMPTY);
        skid_valid_d = (state_d == FULL);
        in_ready_d   = (state_d != FULL);

        main_words_d = main_words_q;
        main_flags_d = main_flags_q;
        if (load_main) begin
            main_words_d = in_words;
            main_flags_d = in_flags;
        end else if (move_skid) begin
            main_words_d = skid_words_q;
            main_flags_d = skid_flags_q;
        end

        skid_words_d = skid_words_q;
        skid_flags_d = skid_flags_q;
        if (load_skid) begin
            skid_words_d = in_words;
            skid_flags_d = in_flags;
        end

        stall_d = stall_q;
        if (main_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_words_q <= '0;
            main_flags_q <= '0;
            skid_words_q <= '0;
            skid_flags_q <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_words_q <= main_words_d;
            main_flags_q <= main_flags_d;
            skid_words_q <= skid_words_d;
            skid_flags_q <= skid_flags_d;
            stall_q      <= stall_d;
        end
    end

    // Bubble when invalid: downstream decodes lane IR_LANE as a NOP. Because
    // main_valid_q clears asynchronously, a reset shows the bubble at once.
    always_comb begin
        out_words                             = '0;
        out_words[IR_LANE*WORD_W +: WORD_W]   = NOP_WORD;
        out_flags                             = '0;
        if (main_valid_q) begin
            out_words = main_words_q;
            out_flags = main_flags_q;
        end
    end

    // skid_valid_q mirrors state FULL; it is kept so each entry carries its
    // own valid bit and the occupancy can be read as the sum of the two.
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign out_valid = main_valid_q;
    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned FLAG_W    = 2;
    localparam int unsigned IR_LANE   = 1;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DW        = NUM_WORDS * WORD_W;
    localparam int unsigned IW        = DW + FLAG_W;
    localparam int          CNT_MAX   = 15;

    logic              clock;
    logic              clrn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_words;
    logic [FLAG_W-1:0] in_flags;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_words;
    logic [FLAG_W-1:0] out_flags;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_skid #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .FLAG_W   (FLAG_W),
        .IR_LANE  (IR_LANE),
        .NOP_WORD (NOP_WORD),
        .CNT_W    (CNT_W)
    ) dut (
        .clock    (clock),
        .clrn     (clrn),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_words (in_words),
        .in_flags (in_flags),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_words(out_words),
        .out_flags(out_flags),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: the stage is a FIFO of depth 2
    logic [IW-1:0] exp_q[$];
    int            m_stall;
    logic          m_in_fire;
    logic          m_out_fire;
    logic [IW-1:0] last_out;

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bubble_words();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            if (k == int'(IR_LANE)) w[k*WORD_W +: WORD_W] = NOP_WORD;
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_words(input logic [7:0] v);
        logic [DW-1:0] w;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            w[k*WORD_W +: WORD_W] = {16'h0, v, 8'(k)};
        end
        return w;
    endfunction

    // advance the model by one rising edge using the inputs currently applied
    task automatic model_edge();
        logic can_take;
        m_in_fire  = 1'b0;
        m_out_fire = 1'b0;
        if (!clrn) begin
            exp_q.delete();
            m_stall = 0;
        end else begin
            can_take   = (exp_q.size() < 2);
            m_out_fire = (exp_q.size() > 0) && out_ready;
            m_in_fire  = in_valid && can_take;
            if ((exp_q.size() > 0) && !out_ready && (m_stall < CNT_MAX)) m_stall++;
            if (m_out_fire) last_out = exp_q.pop_front();
            if (flush) exp_q.delete();
            else if (m_in_fire) exp_q.push_back({in_flags, in_words});
        end
    endtask

    // compare every DUT output against the model
    task automatic check_all();
        logic [DW-1:0]     ew;
        logic [FLAG_W-1:0] ef;
        ew = bubble_words();
        ef = '0;
        if (exp_q.size() > 0) begin
            ew = exp_q[0][DW-1:0];
            ef = exp_q[0][IW-1:DW];
        end
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("occupancy", occupancy, exp_q.size());
        chk("stall_cnt", stall_cnt, m_stall);
        chk("out_words", out_words, ew);
        chk("out_flags", out_flags, ef);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_words  = '0;
        in_flags  = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        idle_inputs();
        step();
        step();
        clrn = 1'b1;
    endtask

    int src;
    int out_cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_stall  = 0;
        last_out = '0;
        clrn     = 1'b0;
        idle_inputs();
        #1;
        do_reset();

        // reset values, pinned as literals
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", out_words, 128'h00000000_00000000_00000013_00000000);

        // single item, 1-cycle latency
        in_valid  = 1'b1;
        in_words  = {32'd4, 32'd3, 32'd2, 32'd1};
        in_flags  = 2'b10;
        out_ready = 1'b1;
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_words", out_words, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("t1_flags", out_flags, 2'b10);
        chk("t1_occ", occupancy, 1);
        chk("t1_stall", stall_cnt, 0);
        in_valid = 1'b0;
        step();
        chk("t1_drained", out_valid, 0);

        // backpressure stream A0..A7
        do_reset();
        src     = 0;
        out_cnt = 0;
        for (int cyc = 0; cyc < 60 && out_cnt < 8; cyc++) begin
            in_valid  = (src < 8);
            in_words  = mk_words(8'(8'hA0 + src));
            in_flags  = 2'(src);
            out_ready = (cyc == 0) || (cyc >= 6);
            step();
            if (m_in_fire) src++;
            if (m_out_fire) begin
                chk("t2_order", last_out[IR_LANE*WORD_W+8 +: 8], 8'(8'hA0 + out_cnt));
                out_cnt++;
            end
            if (cyc == 1) begin
                chk("t2_full_ready", in_ready, 0);
                chk("t2_full_occ", occupancy, 2);
            end
            if (cyc == 5) chk("t2_stall5", stall_cnt, 5);
        end
        chk("t2_count", out_cnt, 8);
        idle_inputs();
        step();
        chk("t2_empty", occupancy, 0);

        // flush while FULL with in_valid=1
        do_reset();
        in_valid = 1'b1;
        in_words = mk_words(8'hB0);
        step();
        in_words = mk_words(8'hB1);
        step();
        chk("t3_pre_occ", occupancy, 2);
        flush    = 1'b1;
        in_words = mk_words(8'hEE);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t3_valid", out_valid, 0);
        chk("t3_bubble", out_words, 128'h00000000_00000000_00000013_00000000);
        chk("t3_flags", out_flags, 0);
        chk("t3_occ", occupancy, 0);
        chk("t3_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("t3_no_ghost", out_valid, 0);

        // flush in ONE with a simultaneous in_fire: the input is dropped
        do_reset();
        in_valid = 1'b1;
        in_words = mk_words(8'hC0);
        step();
        flush    = 1'b1;
        in_words = mk_words(8'hC1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t3b_occ", occupancy, 0);
        repeat (2) step();

        // asynchronous reset while FULL
        do_reset();
        in_valid = 1'b1;
        in_words = mk_words(8'hD0);
        step();
        in_words = mk_words(8'hD1);
        step();
        step();
        chk("t4_pre_occ", occupancy, 2);
        #2;
        clrn = 1'b0;
        exp_q.delete();
        m_stall = 0;
        #1;
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        chk("t4_stall", stall_cnt, 0);
        chk("t4_occ", occupancy, 0);
        chk("t4_bubble", out_words, 128'h00000000_00000000_00000013_00000000);
        step();
        clrn = 1'b1;
        idle_inputs();

        // stall counter saturation (CNT_W = 4)
        do_reset();
        in_valid = 1'b1;
        in_words = mk_words(8'hE0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("t5_stall14", stall_cnt, 14);
            if (i == 15) chk("t5_stall15", stall_cnt, 15);
        end
        chk("t5_sat", stall_cnt, 15);

        // randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 49) == 0);
            in_words  = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_flags  = 2'($urandom_range(0, 3));
            step();
            if (cyc == 500) begin
                clrn = 1'b0;
                idle_inputs();
                step();
                clrn = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
